// File: rtl/wxyz_chk_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wxyz_chk_pkg : shared channel indices and checksum tuple type
// Revision     : 1.0
// ----------------------------------------------------------------------------
package wxyz_chk_pkg;

  localparam int Z_BITS = 28;
  localparam int N_CH   = 4;

  localparam int CH_W = 0;
  localparam int CH_X = 1;
  localparam int CH_Y = 2;
  localparam int CH_Z = 3;

  typedef logic [N_CH-1:0][Z_BITS-1:0] tuple_t;

endpackage
`default_nettype wire

// File: rtl/wxyz_chk_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wxyz_chk_if : expected/observed checksum streams and check results
// Revision    : 1.0
// ----------------------------------------------------------------------------
interface wxyz_chk_if
  import wxyz_chk_pkg::*;
#(
  parameter int zBits   = Z_BITS,
  parameter int cntBits = 16
);

  logic               exp_valid;
  logic               exp_ready;
  logic [zBits-1:0]   exp_w, exp_x, exp_y, exp_z;
  logic               obs_valid;
  logic [zBits-1:0]   obs_w, obs_x, obs_y, obs_z;
  logic               clear_stats;
  logic               chk_valid;
  logic               chk_err;
  logic [3:0]         err_mask;
  logic [cntBits-1:0] err_count;
  logic               underflow;

  modport master (
    output exp_valid, exp_w, exp_x, exp_y, exp_z,
    output obs_valid, obs_w, obs_x, obs_y, obs_z,
    output clear_stats,
    input  exp_ready, chk_valid, chk_err, err_mask, err_count, underflow
  );

  modport slave (
    input  exp_valid, exp_w, exp_x, exp_y, exp_z,
    input  obs_valid, obs_w, obs_x, obs_y, obs_z,
    input  clear_stats,
    output exp_ready, chk_valid, chk_err, err_mask, err_count, underflow
  );

endinterface
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dff      : enabled register with asynchronous active-high reset to zero
// Revision : 1.0
// ----------------------------------------------------------------------------
module dff #(
  parameter int W = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         en,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/wxyz_chk_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// chk_fifo : expected-checksum queue, head is read combinationally
// Revision : 1.0
// ----------------------------------------------------------------------------
module chk_fifo #(
  parameter int depth    = 4,
  parameter int ptrWidth = 2,
  parameter int width    = 112
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [width-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic      [width-1:0] head
);

  logic [ptrWidth-1:0] wr_q, rd_q;
  logic [ptrWidth:0]   count_q, count_d;
  logic [width-1:0]    mem_q [depth];

  // push/pop are pre-qualified by the caller against full/empty
  assign count_d = count_q + (ptrWidth+1)'(push) - (ptrWidth+1)'(pop);
  assign full    = (count_q == (ptrWidth+1)'(depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_q];

  dff #(.W(ptrWidth))   u_wr  (.clk(clk), .rst(rst), .en(push), .d(wr_q + ptrWidth'(1)), .q(wr_q));
  dff #(.W(ptrWidth))   u_rd  (.clk(clk), .rst(rst), .en(pop),  .d(rd_q + ptrWidth'(1)), .q(rd_q));
  dff #(.W(ptrWidth+1)) u_cnt (.clk(clk), .rst(rst), .en(1'b1), .d(count_d),             .q(count_q));

  for (genvar i = 0; i < depth; i++) begin : g_mem
    dff #(.W(width)) u_ent (
      .clk(clk),
      .rst(rst),
      .en (push && (wr_q == ptrWidth'(i))),
      .d  (data_in),
      .q  (mem_q[i])
    );
  end

endmodule
`default_nettype wire

// File: rtl/wxyz_chk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wxyz_chk : compares accumulator checksums against queued expected tuples
// Revision : 1.0
// ----------------------------------------------------------------------------
module wxyz_chk
  import wxyz_chk_pkg::*;
#(
  parameter int zBits    = Z_BITS,
  parameter int depth    = 4,
  parameter int ptrWidth = 2,
  parameter int cntBits  = 16
) (
  input wire logic  clk,
  input wire logic  rst,
  wxyz_chk_if.slave bus
);

  localparam int TUPLE_W = N_CH * zBits;

  tuple_t              exp_t, obs_t, head_t;
  logic [TUPLE_W-1:0]  head_raw;
  logic                full, empty, push, pop;
  logic [N_CH-1:0]     neq, mask_d, mask_q;
  logic                err_d, err_q, valid_q, uf_d, uf_q;
  logic [cntBits-1:0]  cnt_d, cnt_q;

  assign exp_t[CH_W] = bus.exp_w;
  assign exp_t[CH_X] = bus.exp_x;
  assign exp_t[CH_Y] = bus.exp_y;
  assign exp_t[CH_Z] = bus.exp_z;
  assign obs_t[CH_W] = bus.obs_w;
  assign obs_t[CH_X] = bus.obs_x;
  assign obs_t[CH_Y] = bus.obs_y;
  assign obs_t[CH_Z] = bus.obs_z;

  // no bypass: a full queue refuses even when a pop frees a slot this cycle
  assign push = bus.exp_valid && !full;
  assign pop  = bus.obs_valid && !empty;

  chk_fifo #(.depth(depth), .ptrWidth(ptrWidth), .width(TUPLE_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .data_in(exp_t), .full(full), .empty(empty), .head(head_raw)
  );
  assign head_t = head_raw;

  for (genvar c = 0; c < N_CH; c++) begin : g_cmp
    assign neq[c] = (head_t[c] != obs_t[c]);
  end

  assign mask_d = pop ? neq : '0;
  assign err_d  = |mask_d;

  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q | (bus.obs_valid & empty);
    if (bus.clear_stats) begin
      cnt_d = '0;
      uf_d  = 1'b0;
    end else if (err_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + cntBits'(1);
    end
  end

  dff #(.W(1))       u_valid (.clk(clk), .rst(rst), .en(1'b1), .d(pop),    .q(valid_q));
  dff #(.W(N_CH))    u_mask  (.clk(clk), .rst(rst), .en(1'b1), .d(mask_d), .q(mask_q));
  dff #(.W(1))       u_err   (.clk(clk), .rst(rst), .en(1'b1), .d(err_d),  .q(err_q));
  dff #(.W(cntBits)) u_count (.clk(clk), .rst(rst), .en(1'b1), .d(cnt_d),  .q(cnt_q));
  dff #(.W(1))       u_uf    (.clk(clk), .rst(rst), .en(1'b1), .d(uf_d),   .q(uf_q));

  assign bus.exp_ready = !full;
  assign bus.chk_valid = valid_q;
  assign bus.chk_err   = err_q;
  assign bus.err_mask  = mask_q;
  assign bus.err_count = cnt_q;
  assign bus.underflow = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_wxyz_chk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wxyz_chk : directed and random checks against a queue-based reference
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_wxyz_chk;
  import wxyz_chk_pkg::*;

  typedef logic [3:0][27:0] tup_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  tup_t q[$];
  int   m_cnt = 0;
  bit   m_uf  = 1'b0;
  logic [3:0] m_mask = 4'b0;
  bit   m_valid = 1'b0;

  always #5 clk = ~clk;

  wxyz_chk_if #(.zBits(28), .cntBits(4)) bus ();

  wxyz_chk #(.zBits(28), .depth(4), .ptrWidth(2), .cntBits(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic tup_t mk(input int w, input int x, input int y, input int z);
    tup_t t;
    t[0] = 28'(w); t[1] = 28'(x); t[2] = 28'(y); t[3] = 28'(z);
    return t;
  endfunction

  function automatic tup_t rnd_tup();
    tup_t t;
    for (int c = 0; c < 4; c++) t[c] = 28'($urandom);
    return t;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".chk_valid"}, 32'(bus.chk_valid), 32'(m_valid));
    chk({tag, ".err_mask"},  32'(bus.err_mask),  32'(m_mask));
    chk({tag, ".chk_err"},   32'(bus.chk_err),   32'(m_mask != 4'b0));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(m_cnt));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_uf));
    chk({tag, ".exp_ready"}, 32'(bus.exp_ready), 32'(q.size() < 4));
  endtask

  // One clock: drive inputs, advance the reference at the edge, then compare.
  task automatic cycle(input string tag, input bit ev, input tup_t e,
                       input bit ov, input tup_t o, input bit clr);
    bit pop, push;
    bus.exp_valid = ev;
    bus.exp_w = e[0]; bus.exp_x = e[1]; bus.exp_y = e[2]; bus.exp_z = e[3];
    bus.obs_valid = ov;
    bus.obs_w = o[0]; bus.obs_x = o[1]; bus.obs_y = o[2]; bus.obs_z = o[3];
    bus.clear_stats = clr;
    #1;
    chk({tag, ".ready_pre"}, 32'(bus.exp_ready), 32'(q.size() < 4));
    @(posedge clk);
    pop    = ov && (q.size() > 0);
    push   = ev && (q.size() < 4);
    m_mask = 4'b0;
    if (pop) begin
      for (int c = 0; c < 4; c++) m_mask[c] = (q[0][c] != o[c]);
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
    m_valid = pop;
    if (clr) begin
      m_cnt = 0;
      m_uf  = 1'b0;
    end else begin
      if (m_mask != 4'b0 && m_cnt < 15) m_cnt++;
      if (ov && !pop) m_uf = 1'b1;
    end
    #1;
    check_outs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    tup_t t, o;
    bus.exp_valid = 1'b0; bus.obs_valid = 1'b0; bus.clear_stats = 1'b0;
    bus.exp_w = '0; bus.exp_x = '0; bus.exp_y = '0; bus.exp_z = '0;
    bus.obs_w = '0; bus.obs_x = '0; bus.obs_y = '0; bus.obs_z = '0;

    #3;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    idle("post_reset");

    // Matching tuple
    cycle("match_push", 1'b1, mk(10, 20, 30, 40), 1'b0, '0, 1'b0);
    cycle("match_obs",  1'b0, '0, 1'b1, mk(10, 20, 30, 40), 1'b0);
    idle("match_idle");

    // x and z channels differ
    cycle("mis_push", 1'b1, mk(10, 20, 30, 40), 1'b0, '0, 1'b0);
    cycle("mis_obs",  1'b0, '0, 1'b1, mk(10, 21, 30, 41), 1'b0);
    chk("mis_mask_const", 32'(bus.err_mask), 32'(4'b1010));

    // Underflow on empty queue, push in the same cycle is not compared
    cycle("uf_obs", 1'b1, mk(1, 2, 3, 4), 1'b1, mk(1, 2, 3, 4), 1'b0);
    idle("uf_hold");
    cycle("uf_clear", 1'b0, '0, 1'b0, '0, 1'b1);
    cycle("uf_drain", 1'b0, '0, 1'b1, mk(1, 2, 3, 4), 1'b0);

    // Fill, refuse 5th, refuse push alongside pop, then drain
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, rnd_tup(), 1'b0, '0, 1'b0);
    cycle("fill_5th", 1'b1, rnd_tup(), 1'b0, '0, 1'b0);
    cycle("full_pop", 1'b1, rnd_tup(), 1'b1, q[0], 1'b0);
    for (int i = 0; i < 3; i++) cycle("drain", 1'b0, '0, 1'b1, q[0], 1'b0);

    // Saturation at 15 after 17 mismatches, then clear wins over increment
    for (int i = 0; i < 18; i++)
      cycle("sat", 1'b1, mk(i + 1, 5, 6, 7), (i > 0), mk(0, 5, 6, 7), 1'b0);
    chk("sat_hold", 32'(bus.err_count), 32'd15);
    cycle("sat_clear", 1'b0, '0, 1'b1, mk(0, 0, 0, 0), 1'b1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      t = rnd_tup();
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        o = q[0];
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, 4) == 0) o[c] = o[c] ^ 28'(1 << $urandom_range(0, 27));
      end else begin
        o = rnd_tup();
      end
      cycle("rand", ($urandom_range(0, 2) != 0), t, ($urandom_range(0, 2) == 0), o,
            ($urandom_range(0, 30) == 0));
    end

    // Asynchronous reset mid-cycle with queued tuples
    cycle("rst_push0", 1'b1, mk(7, 7, 7, 7), 1'b0, '0, 1'b0);
    cycle("rst_push1", 1'b1, mk(8, 8, 8, 8), 1'b1, mk(0, 0, 0, 0), 1'b0);
    bus.exp_valid = 1'b0; bus.obs_valid = 1'b0; bus.clear_stats = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0; m_uf = 1'b0; m_mask = 4'b0; m_valid = 1'b0;
    check_outs("rst_async");
    #2;
    rst = 1'b0;
    cycle("rst_obs", 1'b0, '0, 1'b1, mk(7, 7, 7, 7), 1'b0);
    idle("rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
